// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//
// Purpose:
//   Shared definitions for the dual-clock FIFO controllers (write side and
//   read side). Holds the pointer-width legal range, the depth derivation
//   and width-agnostic Gray/binary conversion helpers.
//
// Contents:
//   PTR_WIDTH_MIN / PTR_WIDTH_MAX  legal address-width range (2..12)
//   ptr_vec_t                      widest pointer vector (PTR_WIDTH_MAX+1 bits)
//   fifo_depth()                   FIFO depth for a given address width
//   ptr_width_legal()              range check used at elaboration
//   bin2gray() / gray2bin()        conversions on zero-extended vectors
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int PTR_WIDTH_MIN = 2;
    localparam int PTR_WIDTH_MAX = 12;

    // Every pointer fits in this vector once zero-extended. Both conversions
    // below are unaffected by leading zeros, so callers of any narrower
    // width can cast in, convert, and cast back down.
    typedef logic [PTR_WIDTH_MAX:0] ptr_vec_t;

    function automatic int fifo_depth(input int ptr_width);
        return 1 << ptr_width;
    endfunction

    function automatic bit ptr_width_legal(input int ptr_width);
        return (ptr_width >= PTR_WIDTH_MIN) && (ptr_width <= PTR_WIDTH_MAX);
    endfunction

    function automatic ptr_vec_t bin2gray(input ptr_vec_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_vec_t gray2bin(input ptr_vec_t gray);
        ptr_vec_t bin;
        bin = '0;
        bin[PTR_WIDTH_MAX] = gray[PTR_WIDTH_MAX];
        for (int i = PTR_WIDTH_MAX - 1; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// ---------------------------------------------------------------------------
// fifo_gray2bin
//
// Purpose:
//   Parametrised Gray-to-binary converter built as an XOR prefix chain.
//   Used by the write-side controller to decode the synchronised read
//   pointer and by the read-side controller for the write pointer.
//   Purely combinational.
//
// Parameters:
//   WIDTH  vector width (>= 1)
//
// Ports:
//   gray  in   WIDTH  Gray-coded value
//   bin   out  WIDTH  equivalent binary value
// ---------------------------------------------------------------------------
module fifo_gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Binary bit i is the reduction XOR of Gray bits WIDTH-1 down to i.
    // Written as independent reductions rather than a ripple through bin so
    // that no signal depends on another bit of itself.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_wr_ctrl
//
// Purpose:
//   Write-side controller for the dual-clock FIFO. Keeps the binary write
//   pointer, publishes its Gray-coded form to the read domain and derives
//   registered full, programmable almost-full and fill-level outputs from
//   the synchronised read pointer. Runs entirely in the wclk domain.
//
// Configuration macro:
//   FIFO_WR_OVF_EN  when defined, adds the sticky overflow flag (wovf) and
//                   its clear input (wovf_clr). When undefined, both ports
//                   are absent; writes while full are still dropped.
//
// Parameters:
//   PTR_WIDTH      address width, depth = 2**PTR_WIDTH, legal 2..12
//   AFULL_DEFAULT  reset value of the almost-full threshold register
//
// Ports:
//   wclk       in   1            write clock
//   wrst       in   1            synchronous active-high reset
//   winc       in   1            write request, accepted when wfull is 0
//   wq2_rptr   in   PTR_WIDTH+1  Gray read pointer, synchronised to wclk
//   thr_we     in   1            load afull_thr into the threshold register
//   afull_thr  in   PTR_WIDTH+1  new threshold, clipped to the depth
//   wovf_clr   in   1            clear overflow flag (FIFO_WR_OVF_EN only)
//   wovf       out  1            sticky overflow flag (FIFO_WR_OVF_EN only)
//   wptr       out  PTR_WIDTH+1  registered Gray write pointer
//   waddr      out  PTR_WIDTH    RAM write address
//   wfull      out  1            registered full flag
//   wafull     out  1            registered almost-full flag
//   wcount     out  PTR_WIDTH+1  registered fill level, 0..depth
// ---------------------------------------------------------------------------
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH     = 3,
    parameter int AFULL_DEFAULT = 2**PTR_WIDTH - 1
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 winc,
    input  logic [PTR_WIDTH:0]   wq2_rptr,
    input  logic                 thr_we,
    input  logic [PTR_WIDTH:0]   afull_thr,
`ifdef FIFO_WR_OVF_EN
    input  logic                 wovf_clr,
    output logic                 wovf,
`endif
    output logic [PTR_WIDTH:0]   wptr,
    output logic [PTR_WIDTH-1:0] waddr,
    output logic                 wfull,
    output logic                 wafull,
    output logic [PTR_WIDTH:0]   wcount
);

    localparam int DEPTH = fifo_depth(PTR_WIDTH);

    // Depth expressed at pointer width, used for threshold clipping.
    localparam logic [PTR_WIDTH:0] DEPTH_VEC = (PTR_WIDTH+1)'(DEPTH);

    // The reset threshold is clipped like a runtime load would be, so an
    // oversized AFULL_DEFAULT can never leave wafull permanently low.
    localparam logic [PTR_WIDTH:0] THR_RESET =
        (AFULL_DEFAULT > DEPTH) ? DEPTH_VEC : (PTR_WIDTH+1)'(AFULL_DEFAULT);

    if (!ptr_width_legal(PTR_WIDTH)) begin : g_illegal_width
        $error("fifo_wr_ctrl: PTR_WIDTH must lie in 2..12");
    end

    logic [PTR_WIDTH:0] wbin;
    logic [PTR_WIDTH:0] wbin_next;
    logic [PTR_WIDTH:0] wgray_next;
    logic [PTR_WIDTH:0] rbin;
    logic [PTR_WIDTH:0] cnt_c;
    logic [PTR_WIDTH:0] thr;
    logic               wacc;
    logic               full_c;

    // Decode the synchronised read pointer once; the fill level is then a
    // plain modular subtraction of binary pointers.
    fifo_gray2bin #(
        .WIDTH(PTR_WIDTH + 1)
    ) u_rptr_g2b (
        .gray(wq2_rptr),
        .bin (rbin)
    );

    // Next-pointer, full and fill-level computation. Everything here looks
    // at the pointer after this cycle's write so that the registered flags
    // describe the FIFO state the next write will see. Full is the classic
    // Gray comparison: top two bits inverted, remaining bits equal, which
    // means the write pointer is exactly one lap ahead of the read pointer.
    always_comb begin
        wacc       = winc & ~wfull;
        wbin_next  = wbin + (PTR_WIDTH+1)'(wacc);
        wgray_next = (PTR_WIDTH+1)'(bin2gray(ptr_vec_t'(wbin_next)));
        full_c     = (wgray_next[PTR_WIDTH:PTR_WIDTH-1] == ~wq2_rptr[PTR_WIDTH:PTR_WIDTH-1])
                   & (wgray_next[PTR_WIDTH-2:0] == wq2_rptr[PTR_WIDTH-2:0]);
        cnt_c      = wbin_next - rbin;
    end

    // The RAM is written at the current pointer; the increment lands on the
    // same edge as the write, so the address is never the next pointer.
    assign waddr = wbin[PTR_WIDTH-1:0];

    // Pointer and flag registers. The threshold written this cycle only
    // affects the almost-full comparison made on the following edge, since
    // the comparison below still sees the old register value.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin   <= '0;
            wptr   <= '0;
            wfull  <= 1'b0;
            wafull <= 1'b0;
            wcount <= '0;
            thr    <= THR_RESET;
        end else begin
            wbin   <= wbin_next;
            wptr   <= wgray_next;
            wfull  <= full_c;
            wafull <= (cnt_c >= thr);
            wcount <= cnt_c;
            if (thr_we) begin
                thr <= (afull_thr > DEPTH_VEC) ? DEPTH_VEC : afull_thr;
            end
        end
    end

`ifdef FIFO_WR_OVF_EN
    // Sticky overflow: a write attempted while full sets the flag and wins
    // over a clear arriving in the same cycle, so no overflow event is lost.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wovf <= 1'b0;
        end else if (winc & wfull) begin
            wovf <= 1'b1;
        end else if (wovf_clr) begin
            wovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_ctrl
//
// Purpose:
//   Self-checking bench for fifo_wr_ctrl with PTR_WIDTH = 3 (depth 8).
//   A reference model tracks the FIFO as integer write and read counts;
//   the read pointer fed to the DUT is derived from the model's read count.
//   Covers reset, a fill-to-full vector table, threshold loads, wrap-around,
//   simultaneous read/write, mid-fill reset, overflow (FIFO_WR_OVF_EN) and
//   a randomised run.
// ---------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

    localparam int PW    = 3;
    localparam int DEPTH = 8;

    logic          wclk = 1'b0;
    logic          wrst;
    logic          winc;
    logic          thr_we;
    logic [PW:0]   wq2_rptr;
    logic [PW:0]   afull_thr;
    logic [PW:0]   wptr;
    logic [PW-1:0] waddr;
    logic          wfull;
    logic          wafull;
    logic [PW:0]   wcount;
`ifdef FIFO_WR_OVF_EN
    logic          wovf_clr;
    logic          wovf;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: total accepted writes, reads visible to the write side,
    // threshold, and the registered flags as they should read after an edge.
    int m_wr;
    int rd_ptr;
    int m_thr;
    int m_count;
    bit m_full;
    bit m_afull;
    bit m_ovf;

    typedef struct {
        bit inc;
        int exp_count;
        bit exp_full;
        bit exp_afull;
        int exp_wptr;
        int exp_waddr;
        bit exp_ovf;
    } vec_t;

    vec_t vecs[11];

    fifo_wr_ctrl #(
        .PTR_WIDTH(PW)
    ) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .winc     (winc),
        .wq2_rptr (wq2_rptr),
        .thr_we   (thr_we),
        .afull_thr(afull_thr),
`ifdef FIFO_WR_OVF_EN
        .wovf_clr (wovf_clr),
        .wovf     (wovf),
`endif
        .wptr     (wptr),
        .waddr    (waddr),
        .wfull    (wfull),
        .wafull   (wafull),
        .wcount   (wcount)
    );

    always #5 wclk = ~wclk;

    function automatic int toGray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit inc, input bit twe,
                                 input int tval, input bit oclr);
        wrst      = rst;
        winc      = inc;
        thr_we    = twe;
        afull_thr = (PW+1)'(tval);
        wq2_rptr  = (PW+1)'(toGray(rd_ptr % (2 * DEPTH)));
`ifdef FIFO_WR_OVF_EN
        wovf_clr  = oclr;
`endif
        if (oclr && rst) begin
            m_ovf = 1'b0;
        end
    endtask

    // FIFO-level view of one clock edge: a write is taken only when the
    // FIFO was not full, the fill level is writes minus visible reads, and a
    // threshold load applies from the following edge on.
    task automatic modelEdge(input bit rst, input bit inc, input bit twe,
                             input int tval, input bit oclr);
        int fill;
        if (rst) begin
            m_wr    = 0;
            m_count = 0;
            m_full  = 1'b0;
            m_afull = 1'b0;
            m_thr   = DEPTH - 1;
            m_ovf   = 1'b0;
        end else begin
            if (inc && m_full) begin
                m_ovf = 1'b1;
            end else if (oclr) begin
                m_ovf = 1'b0;
            end
            if (inc && !m_full) begin
                m_wr++;
            end
            fill    = m_wr - rd_ptr;
            m_count = fill;
            m_full  = (fill == DEPTH);
            m_afull = (fill >= m_thr);
            if (twe) begin
                m_thr = (tval > DEPTH) ? DEPTH : tval;
            end
        end
    endtask

    task automatic tick(input bit rst, input bit inc, input bit twe,
                        input int tval, input bit oclr);
        applyStimulus(rst, inc, twe, tval, oclr);
        @(posedge wclk);
        modelEdge(rst, inc, twe, tval, oclr);
        #1;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_wcount"}, int'(wcount), m_count);
        checkOutput({tag, "_wfull"},  int'(wfull),  int'(m_full));
        checkOutput({tag, "_wafull"}, int'(wafull), int'(m_afull));
        checkOutput({tag, "_wptr"},   int'(wptr),   toGray(m_wr % (2 * DEPTH)));
        checkOutput({tag, "_waddr"},  int'(waddr),  m_wr % DEPTH);
`ifdef FIFO_WR_OVF_EN
        checkOutput({tag, "_wovf"},   int'(wovf),   int'(m_ovf));
`endif
    endtask

    task automatic doReset();
        rd_ptr = 0;
        tick(1'b1, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic writeN(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b1, 1'b0, 0, 1'b0);
            checkModel(tag);
        end
    endtask

    initial begin
        bit rr;
        bit ri;
        bit rt;
        bit rc;
        int rv;

        // Fill from empty to full, then three more write attempts while full.
        vecs[0]  = '{1'b1, 1, 1'b0, 1'b0, 'h1, 1, 1'b0};
        vecs[1]  = '{1'b1, 2, 1'b0, 1'b0, 'h3, 2, 1'b0};
        vecs[2]  = '{1'b1, 3, 1'b0, 1'b0, 'h2, 3, 1'b0};
        vecs[3]  = '{1'b1, 4, 1'b0, 1'b0, 'h6, 4, 1'b0};
        vecs[4]  = '{1'b1, 5, 1'b0, 1'b0, 'h7, 5, 1'b0};
        vecs[5]  = '{1'b1, 6, 1'b0, 1'b0, 'h5, 6, 1'b0};
        vecs[6]  = '{1'b1, 7, 1'b0, 1'b1, 'h4, 7, 1'b0};
        vecs[7]  = '{1'b1, 8, 1'b1, 1'b1, 'hC, 0, 1'b0};
        vecs[8]  = '{1'b1, 8, 1'b1, 1'b1, 'hC, 0, 1'b1};
        vecs[9]  = '{1'b1, 8, 1'b1, 1'b1, 'hC, 0, 1'b1};
        vecs[10] = '{1'b1, 8, 1'b1, 1'b1, 'hC, 0, 1'b1};

        m_wr = 0; rd_ptr = 0; m_thr = DEPTH - 1; m_count = 0;
        m_full = 1'b0; m_afull = 1'b0; m_ovf = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);
        #2;

        // Reset state
        doReset();
        checkOutput("rst_wcount", int'(wcount), 0);
        checkOutput("rst_wfull",  int'(wfull),  0);
        checkOutput("rst_wafull", int'(wafull), 0);
        checkOutput("rst_wptr",   int'(wptr),   0);
        checkOutput("rst_waddr",  int'(waddr),  0);

        // Table: fill to full, writes while full are dropped
        for (int i = 0; i < 11; i++) begin
            tick(1'b0, vecs[i].inc, 1'b0, 0, 1'b0);
            checkOutput($sformatf("vec%0d_wcount", i), int'(wcount), vecs[i].exp_count);
            checkOutput($sformatf("vec%0d_wfull", i),  int'(wfull),  int'(vecs[i].exp_full));
            checkOutput($sformatf("vec%0d_wafull", i), int'(wafull), int'(vecs[i].exp_afull));
            checkOutput($sformatf("vec%0d_wptr", i),   int'(wptr),   vecs[i].exp_wptr);
            checkOutput($sformatf("vec%0d_waddr", i),  int'(waddr),  vecs[i].exp_waddr);
`ifdef FIFO_WR_OVF_EN
            checkOutput($sformatf("vec%0d_wovf", i),   int'(wovf),   int'(vecs[i].exp_ovf));
`endif
        end

`ifdef FIFO_WR_OVF_EN
        // Clear together with a write while full keeps the flag set
        tick(1'b0, 1'b1, 1'b0, 0, 1'b1);
        checkOutput("ovf_clr_collide", int'(wovf), 1);
        checkOutput("ovf_ptr_held",    int'(wptr), 'hC);
        tick(1'b0, 1'b0, 1'b0, 0, 1'b1);
        checkOutput("ovf_cleared", int'(wovf), 0);
        tick(1'b0, 1'b0, 1'b0, 0, 1'b0);
        checkOutput("ovf_stays_clear", int'(wovf), 0);
`endif

        // Threshold 5: wafull rises on the same edge wcount reaches 5
        doReset();
        tick(1'b0, 1'b0, 1'b1, 5, 1'b0);
        checkModel("thr5_load");
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 1'b0, 0, 1'b0);
            checkModel("thr5");
            checkOutput("thr5_wafull", int'(wafull), (i == 4) ? 1 : 0);
        end

        // Threshold 0: almost-full with an empty FIFO
        doReset();
        tick(1'b0, 1'b0, 1'b1, 0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 0, 1'b0);
        checkOutput("thr0_wafull", int'(wafull), 1);
        checkOutput("thr0_wcount", int'(wcount), 0);

        // Oversized threshold is clipped to the depth: wafull tracks wfull
        doReset();
        tick(1'b0, 1'b0, 1'b1, 15, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b0, 1'b1, 1'b0, 0, 1'b0);
            checkModel("thrclip");
            checkOutput("thrclip_wafull", int'(wafull), (i == DEPTH - 1) ? 1 : 0);
        end

        // Wrap-around: fill, drain via read pointer, fill again
        doReset();
        writeN(DEPTH, "wrap_fill1");
        for (int i = 0; i < DEPTH; i++) begin
            rd_ptr++;
            tick(1'b0, 1'b0, 1'b0, 0, 1'b0);
            checkModel("wrap_drain");
            checkOutput("wrap_drain_wfull", int'(wfull), 0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b0, 1'b1, 1'b0, 0, 1'b0);
            checkModel("wrap_fill2");
            checkOutput("wrap_fill2_wfull", int'(wfull), (i == DEPTH - 1) ? 1 : 0);
        end
        checkOutput("wrap_wptr", int'(wptr), 0);

        // Write and read every cycle at depth 7
        doReset();
        writeN(DEPTH - 1, "sim_fill");
        for (int i = 0; i < 6; i++) begin
            rd_ptr++;
            tick(1'b0, 1'b1, 1'b0, 0, 1'b0);
            checkModel("sim_rw");
            checkOutput("sim_rw_wcount", int'(wcount), 7);
            checkOutput("sim_rw_wfull",  int'(wfull),  0);
        end

        // Reset at wcount 5 together with a write
        doReset();
        writeN(5, "mid_fill");
        rd_ptr = 0;
        tick(1'b1, 1'b1, 1'b0, 0, 1'b0);
        checkOutput("midrst_wcount", int'(wcount), 0);
        checkOutput("midrst_wfull",  int'(wfull),  0);
        checkOutput("midrst_wafull", int'(wafull), 0);
        checkOutput("midrst_wptr",   int'(wptr),   0);
        checkOutput("midrst_waddr",  int'(waddr),  0);
`ifdef FIFO_WR_OVF_EN
        checkOutput("midrst_wovf",   int'(wovf),   0);
`endif
        for (int i = 0; i < DEPTH - 1; i++) begin
            tick(1'b0, 1'b1, 1'b0, 0, 1'b0);
            checkModel("midrst_thr");
            checkOutput("midrst_thr7_wafull", int'(wafull), (i == DEPTH - 2) ? 1 : 0);
        end

        // Randomised run against the model
        doReset();
        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(99) == 0);
            ri = ($urandom_range(3) != 0);
            rt = ($urandom_range(15) == 0);
            rv = int'($urandom_range(15));
            rc = ($urandom_range(7) == 0);
            if (rr) begin
                rd_ptr = 0;
            end else if (rd_ptr < m_wr && $urandom_range(1) == 1) begin
                rd_ptr++;
            end
            tick(rr, ri, rt, rv, rc);
            checkModel("rand");
        end

        $display("[TB] model end state: writes=%0d reads=%0d ovf=%0b", m_wr, rd_ptr, m_ovf);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
